// File: rtl/chooser_switch_sched.sv
// Round-robin scheduler sharing one ChooserSwitch64 datapath between two requesters.
// Optional WAIT timeout/abort is enabled by defining CHOOSER_SCHED_TIMEOUT_EN.
module chooser_switch_sched #(
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic              clk,
    input  logic              rst_user,
    input  logic              req1,
    input  logic              req2,
    output logic              beta_flag,
    output logic              sw_sta,
    input  logic              sw_done,
    input  logic [DATA_W-1:0] sw_dataout,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              result_src,
    output logic              ack1,
    output logic              ack2,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state, state_nxt;
    logic             last_grant;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             grant, grant_id, capture;

    if (TIMEOUT_CYC > (1 << CNT_W) - 1) begin : g_bad_cnt_w
        $error("CNT_W too narrow to hold TIMEOUT_CYC");
    end

`ifdef CHOOSER_SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic abort;
`endif

    always_ff @(posedge clk or posedge rst_user) begin
        if (rst_user) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        grant        = 1'b0;
        grant_id     = last_grant;
        capture      = 1'b0;
`ifdef CHOOSER_SCHED_TIMEOUT_EN
        abort        = 1'b0;
`endif
        case (state)
            IDLE: if (req1 || req2) begin
                grant     = 1'b1;
                // tie goes to whoever was not granted last
                grant_id  = (req1 && req2) ? ~last_grant : req2;
                state_nxt = ISSUE;
            end
            ISSUE: begin
                state_nxt    = WAIT;
                wait_cnt_nxt = '0;
            end
            WAIT: begin
                if (sw_done) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
`ifdef CHOOSER_SCHED_TIMEOUT_EN
                else if (wait_cnt == TO_LAST) begin
                    abort     = 1'b1;
                    state_nxt = DONE;
                end
`endif
                else if (wait_cnt != '1) begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Every output is a flop fed from the FSM decisions above.
    always_ff @(posedge clk or posedge rst_user) begin
        if (rst_user) begin
            last_grant   <= 1'b1;
            beta_flag    <= 1'b0;
            sw_sta       <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            result_src   <= 1'b0;
            ack1         <= 1'b0;
            ack2         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sw_sta <= grant;
            if (grant) begin
                beta_flag  <= grant_id;
                last_grant <= grant_id;
            end
            result_valid <= capture;
            if (capture) begin
                result     <= sw_dataout;
                result_src <= beta_flag;
            end
            ack1 <= (state == WAIT) && (state_nxt == DONE) && !beta_flag;
            ack2 <= (state == WAIT) && (state_nxt == DONE) &&  beta_flag;
            busy <= (state_nxt != IDLE);
        end
    end

`ifdef CHOOSER_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst_user) begin
        if (rst_user)   timeout_err <= 1'b0;
        else if (abort) timeout_err <= 1'b1;
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_chooser_switch_sched.sv
// Directed bench for chooser_switch_sched: drives/samples on negedge, switch modelled as sta->done 1 clk.
module tb_chooser_switch_sched;

    logic        clk = 1'b0;
    logic        rst_user, req1, req2, sw_done;
    logic [63:0] sw_dataout, result;
    logic        beta_flag, sw_sta, result_valid, result_src, ack1, ack2, busy, timeout_err;
    logic [63:0] din1, din2, exp_res;
    logic        done_en, done_inj, done_mdl;
    int          total = 0;
    int          bad   = 0;
    int          ph, id;

    chooser_switch_sched dut (
        .clk(clk), .rst_user(rst_user), .req1(req1), .req2(req2),
        .beta_flag(beta_flag), .sw_sta(sw_sta), .sw_done(sw_done), .sw_dataout(sw_dataout),
        .result(result), .result_valid(result_valid), .result_src(result_src),
        .ack1(ack1), .ack2(ack2), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst_user)
        if (rst_user) done_mdl <= 1'b0;
        else          done_mdl <= sw_sta & done_en;

    assign sw_done    = done_mdl | done_inj;
    assign sw_dataout = beta_flag ? din2 : din1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".outs"},
            {beta_flag, sw_sta, result_valid, result_src, ack1, ack2, busy, timeout_err}, 64'h0);
        chk({tag, ".result"}, result, 64'h0);
    endtask

    task automatic do_reset();
        rst_user = 1'b1;
        cyc();
        chk_zero("reset");
        rst_user = 1'b0;
    endtask

    initial begin
        rst_user = 1'b1; req1 = 0; req2 = 0; done_en = 1; done_inj = 0;
        din1 = 64'h0; din2 = 64'h0;
        cyc();
        do_reset();

        // single req1
        req1 = 1; din1 = 64'h3FF0000000000000; din2 = 64'h0;
        cyc();
        chk("t1.sta", sw_sta, 1); chk("t1.beta", beta_flag, 0); chk("t1.busy", busy, 1);
        chk("t1.ack_early", ack1, 0);
        cyc();
        chk("t1.sta_off", sw_sta, 0); chk("t1.ack_wait", ack1, 0); chk("t1.rv_wait", result_valid, 0);
        cyc();
        chk("t1.result", result, 64'h3FF0000000000000); chk("t1.rv", result_valid, 1);
        chk("t1.src", result_src, 0); chk("t1.ack1", ack1, 1); chk("t1.ack2", ack2, 0);
        req1 = 0;
        cyc();
        chk("t1.ack1_off", ack1, 0); chk("t1.rv_off", result_valid, 0); chk("t1.idle", busy, 0);
        chk("t1.hold", result, 64'h3FF0000000000000);

        // both held: grants 1,2,1
        do_reset();
        req1 = 1; req2 = 1; din1 = 64'h1111; din2 = 64'h2222;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            ph = (i - 1) % 4;
            id = ((i - 1) / 4) % 2;
            chk($sformatf("t2.sta%0d", i), sw_sta, (ph == 0));
            chk($sformatf("t2.beta%0d", i), beta_flag, id);
            chk($sformatf("t2.ack1_%0d", i), ack1, (ph == 2 && id == 0));
            chk($sformatf("t2.ack2_%0d", i), ack2, (ph == 2 && id == 1));
            chk($sformatf("t2.rv%0d", i), result_valid, (ph == 2));
            if (ph == 2) begin
                chk($sformatf("t2.res%0d", i), result, (id == 1) ? 64'h2222 : 64'h1111);
                chk($sformatf("t2.src%0d", i), result_src, id);
            end
            if (i == 11) begin req1 = 0; req2 = 0; end
        end
        cyc();
        chk("t2.idle", busy, 0); chk("t2.no_sta", sw_sta, 0);

        // req2 alone after reset
        do_reset();
        req2 = 1; din1 = 64'h0; din2 = 64'hC000000000000000;
        cyc();
        chk("t3.beta", beta_flag, 1); chk("t3.sta", sw_sta, 1);
        cyc();
        cyc();
        chk("t3.result", result, 64'hC000000000000000); chk("t3.src", result_src, 1);
        chk("t3.ack2", ack2, 1); chk("t3.ack1", ack1, 0);
        req2 = 0;
        cyc();

        // reset while in WAIT
        req1 = 1; din1 = 64'h5555;
        cyc();
        cyc();
        req1 = 0;
        rst_user = 1;
        #1;
        chk_zero("t4.async");
        cyc();
        rst_user = 0; req1 = 1; din1 = 64'h7777;
        chk("t4.no_ack", ack1, 0);
        cyc();
        chk("t4.sta", sw_sta, 1); chk("t4.ack_none", ack1, 0);
        cyc();
        cyc();
        chk("t4.ack1", ack1, 1); chk("t4.result", result, 64'h7777);
        req1 = 0;
        exp_res = 64'h7777;
        cyc();

        // stray done in IDLE
        din1 = 64'hDEAD; din2 = 64'hDEAD; done_inj = 1;
        cyc();
        done_inj = 0;
        chk("t5.rv", result_valid, 0); chk("t5.result", result, exp_res); chk("t5.busy", busy, 0);
        cyc();
        chk("t5.rv2", result_valid, 0); chk("t5.result2", result, exp_res);

        // switch never answers
        done_en = 0; din1 = 64'h1234; req1 = 1;
        cyc();
        req1 = 0;
`ifdef CHOOSER_SCHED_TIMEOUT_EN
        for (int i = 2; i <= 17; i++) begin
            cyc();
            chk($sformatf("t6.to_early%0d", i), timeout_err, 0);
            chk($sformatf("t6.ack_early%0d", i), ack1, 0);
        end
        cyc();
        chk("t6.to", timeout_err, 1); chk("t6.ack1", ack1, 1);
        chk("t6.rv", result_valid, 0); chk("t6.result", result, exp_res);
        cyc();
        chk("t6.sticky", timeout_err, 1); chk("t6.ack_off", ack1, 0); chk("t6.idle", busy, 0);
        do_reset();
`else
        for (int i = 2; i <= 26; i++) begin
            cyc();
            chk($sformatf("t6.busy%0d", i), busy, 1);
            chk($sformatf("t6.ack%0d", i), ack1, 0);
        end
        done_inj = 1;
        cyc();
        done_inj = 0;
        chk("t6.rv", result_valid, 1); chk("t6.result", result, 64'h1234);
        chk("t6.ack1", ack1, 1); chk("t6.to", timeout_err, 0);
        cyc();
`endif
        done_en = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
